hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset; ports in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IFID_RegRs  in  5  rs of instruction in ID
- IFID_RegRt  in  5  rt of instruction in ID
- IFID_UseRt  in  1  ID instruction reads rt
- IDEX_RegRt  in  5  destination of instruction in EX
- IDEX_MemRead  in  1  EX instruction is a load
- branch_taken  in  1  ID-resolved taken branch or jump
- ICache_stall  in  1  instruction cache miss busy
- DCache_stall  in  1  data cache miss busy
- cnt_clr  in  1  synchronous clear of performance counters
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write  out  1 each  stage-register write enables
- IFID_Flush  out  1  zero the IF/ID register
- IDEX_Bubble  out  1  load NOP control into ID/EX
- freeze_cnt, bubble_cnt, flush_cnt  out  16 each  performance counters

Function
REQ-002 Control outputs SHALL be combinational from the current inputs and registered state; hazard response occurs in the same cycle as detection (zero latency).
REQ-003 mem_stall = ICache_stall | DCache_stall.
REQ-004 load_use = IDEX_MemRead & (IDEX_RegRt != 0) & ((IDEX_RegRt == IFID_RegRs) | (IFID_UseRt & (IDEX_RegRt == IFID_RegRt))).
REQ-005 The FSM SHALL have two states: RUN and FREEZE; reset state RUN.
REQ-006 Priority, highest first: mem_stall, load_use, flush, normal.
REQ-007 mem_stall=1 (either state): all five write enables 0, IFID_Flush=0, IDEX_Bubble=0; next state FREEZE.
REQ-008 While mem_stall=1, branch_taken=1 SHALL set flush_pending; flush_pending holds until consumed.
REQ-009 mem_stall=0 and load_use=1: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IDEX_Write/EXMEM_Write/MEMWB_Write=1, IFID_Flush=0; branch_taken ignored this cycle (re-evaluated next cycle); flush_pending retained.
REQ-010 mem_stall=0, load_use=0, (branch_taken | flush_pending)=1: all write enables 1, IFID_Flush=1, IDEX_Bubble=0; flush_pending cleared at clock edge.
REQ-011 Otherwise: all write enables 1, IFID_Flush=0, IDEX_Bubble=0.
REQ-012 FREEZE -> RUN on first cycle with mem_stall=0; that release cycle obeys REQ-009..011 normally (no extra dead cycle).
REQ-013 Simultaneous ICache_stall and DCache_stall SHALL behave as one freeze; freeze ends only when both are 0.
REQ-014 freeze_cnt increments each cycle with mem_stall=1; bubble_cnt each cycle IDEX_Bubble=1; flush_cnt each cycle IFID_Flush=1.
REQ-015 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-016 cnt_clr=1 SHALL zero all counters at the clock edge, overriding any increment that cycle; FSM and flush_pending unaffected.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state RUN, flush_pending=0, all counters 0.
REQ-018 While rst_n=0, all write enables, IFID_Flush and IDEX_Bubble SHALL be 0.
REQ-019 Reset asserted mid-freeze or with flush pending SHALL discard the pending flush; first cycle after release behaves per REQ-011 given quiet inputs.

Verification
REQ-020 Load-use: IDEX_MemRead=1, IDEX_RegRt=5, IFID_RegRs=5 for one cycle -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1, bubble_cnt 0->1; IDEX_RegRt=0 instead -> no stall.
REQ-021 rt gating: IDEX_RegRt=7, IFID_RegRt=7, IFID_UseRt=0 -> no stall; IFID_UseRt=1 -> stall.
REQ-022 Branch during freeze: DCache_stall=1 for 3 cycles with branch_taken pulsed in cycle 2 -> all enables 0 for 3 cycles, freeze_cnt=3; release cycle IFID_Flush=1, flush_cnt=1; following cycle IFID_Flush=0.
REQ-023 Load-use plus branch: load_use=1 and branch_taken=1 same cycle -> IDEX_Bubble=1, IFID_Flush=0; next cycle load_use=0, branch_taken=1 -> IFID_Flush=1.
REQ-024 Saturation/clear: hold ICache_stall 65540 cycles -> freeze_cnt=16'hFFFF; cnt_clr pulse -> 0 next cycle.
REQ-025 Reset mid-freeze with flush_pending set -> after rst_n release with quiet inputs, IFID_Flush=0, all enables 1, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes the whole pipe on cache misses, inserts
// load-use bubbles, flushes IF/ID on taken branches, and keeps saturating event counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_RegRs,
  input  logic [4:0]  IFID_RegRt,
  input  logic        IFID_UseRt,
  input  logic [4:0]  IDEX_RegRt,
  input  logic        IDEX_MemRead,
  input  logic        branch_taken,
  input  logic        ICache_stall,
  input  logic        DCache_stall,
  input  logic        cnt_clr,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        MEMWB_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic [15:0] freeze_cnt,
  output logic [15:0] bubble_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t state, nextState;
  logic   memStall, loadUse;
  logic   flushPending, flushPendingNext;

  assign memStall = ICache_stall | DCache_stall;
  assign loadUse  = IDEX_MemRead && (IDEX_RegRt != 5'd0) &&
                    ((IDEX_RegRt == IFID_RegRs) ||
                     (IFID_UseRt && (IDEX_RegRt == IFID_RegRt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      flushPending <= 1'b0;
    end else begin
      state        <= nextState;
      flushPending <= flushPendingNext;
    end
  end

  // A branch seen during a freeze is remembered and replayed on the release cycle.
  always_comb begin
    PC_Write         = 1'b1;
    IFID_Write       = 1'b1;
    IDEX_Write       = 1'b1;
    EXMEM_Write      = 1'b1;
    MEMWB_Write      = 1'b1;
    IFID_Flush       = 1'b0;
    IDEX_Bubble      = 1'b0;
    flushPendingNext = flushPending;

    case (state)
      RUN:     nextState = memStall ? FREEZE : RUN;
      FREEZE:  nextState = memStall ? FREEZE : RUN;
      default: nextState = RUN;
    endcase

    if (!rst_n) begin
      PC_Write         = 1'b0;
      IFID_Write       = 1'b0;
      IDEX_Write       = 1'b0;
      EXMEM_Write      = 1'b0;
      MEMWB_Write      = 1'b0;
      flushPendingNext = 1'b0;
      nextState        = RUN;
    end else if (memStall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
      if (branch_taken) flushPendingNext = 1'b1;
    end else if (loadUse) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else if (branch_taken || flushPending) begin
      IFID_Flush       = 1'b1;
      flushPendingNext = 1'b0;
    end
  end

  // Clear wins over any increment in the same cycle; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze_cnt <= 16'd0;
      bubble_cnt <= 16'd0;
      flush_cnt  <= 16'd0;
    end else if (cnt_clr) begin
      freeze_cnt <= 16'd0;
      bubble_cnt <= 16'd0;
      flush_cnt  <= 16'd0;
    end else begin
      if (memStall && (freeze_cnt != 16'hFFFF))   freeze_cnt <= freeze_cnt + 16'd1;
      if (IDEX_Bubble && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
      if (IFID_Flush && (flush_cnt != 16'hFFFF))   flush_cnt  <= flush_cnt + 16'd1;
    end
  end

endmodule
